// File: rtl/iterative_grid_remover_if.sv
// Load/readout bus for iterative_grid_remover: row load handshake and row readout.
interface iterative_grid_remover_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) ();
  logic                     load_valid;
  logic                     load_ready;
  logic [WIDTH-1:0]         load_row;
  logic [$clog2(DEPTH)-1:0] rd_sel;
  logic [WIDTH-1:0]         rd_row;

  modport master (
    output load_valid, load_row, rd_sel,
    input  load_ready, rd_row
  );

  modport slave (
    input  load_valid, load_row, rd_sel,
    output load_ready, rd_row
  );
endinterface

// File: rtl/iterative_grid_remover.sv
// Iterative grid remover: loads a WIDTH x DEPTH bit grid row by row, then
// repeatedly clears every set cell with fewer than THRESH set 8-neighbours
// (one full simultaneous sweep per clock) until a sweep removes nothing or
// MAX_SWEEPS is reached.
module iterative_grid_remover #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned THRESH     = 4,
  parameter int unsigned MAX_SWEEPS = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  iterative_grid_remover_if.slave              bus,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 limit_hit,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]     total_removed,
  output logic [$clog2(MAX_SWEEPS+1)-1:0]      sweep_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned TOT_W = $clog2(WIDTH*DEPTH+1);
  localparam int unsigned SW_W  = $clog2(MAX_SWEEPS+1);
  localparam int unsigned NBR_W = 4;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_grid [DEPTH];
  logic [PTR_W-1:0] r_row_ptr;
  logic [TOT_W-1:0] r_total;
  logic [SW_W-1:0]  r_sweeps;
  logic             r_limit_hit;

  logic [WIDTH+1:0] w_pad [DEPTH+2];
  logic [WIDTH-1:0] w_rm  [DEPTH];
  logic [TOT_W-1:0] w_rm_count;
  logic             w_accept;
  logic             w_last_row;
  logic             w_sweep_last;

  assign bus.load_ready = rst || (r_state != S_SWEEP);
  assign w_accept       = bus.load_valid && bus.load_ready;
  assign w_last_row     = (r_row_ptr == PTR_W'(DEPTH-1));
  assign w_sweep_last   = (r_sweeps == SW_W'(MAX_SWEEPS-1));

  assign busy          = (r_state == S_SWEEP);
  assign done          = (r_state == S_DONE);
  assign limit_hit     = r_limit_hit;
  assign total_removed = r_total;
  assign sweep_count   = r_sweeps;
  assign bus.rd_row    = (32'(bus.rd_sel) < DEPTH) ? r_grid[bus.rd_sel] : '0;

  // Zero-padded copy of the grid so out-of-grid neighbours read as 0
  always_comb begin
    w_pad[0]       = '0;
    w_pad[DEPTH+1] = '0;
    for (int r = 0; r < int'(DEPTH); r++) begin
      w_pad[r+1] = {1'b0, r_grid[r], 1'b0};
    end
  end

  // Removable-cell mask and its population count, all against the current snapshot
  always_comb begin
    logic [NBR_W-1:0] nbr;
    nbr        = '0;
    w_rm_count = '0;
    for (int r = 0; r < int'(DEPTH); r++) begin
      w_rm[r] = '0;
      for (int c = 0; c < int'(WIDTH); c++) begin
        nbr = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              nbr = nbr + NBR_W'(w_pad[r+dr][c+dc]);
            end
          end
        end
        w_rm[r][c] = r_grid[r][c] && (32'(nbr) < THRESH);
        w_rm_count = w_rm_count + TOT_W'(w_rm[r][c]);
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_last_row ? S_SWEEP : S_LOAD;
        end
      end
      S_SWEEP: begin
        if ((w_rm_count == '0) || w_sweep_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grid storage, row pointer and sweep statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        r_grid[r] <= '0;
      end
      r_row_ptr   <= '0;
      r_total     <= '0;
      r_sweeps    <= '0;
      r_limit_hit <= 1'b0;
    end else if (r_state == S_SWEEP) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        r_grid[r] <= r_grid[r] & ~w_rm[r];
      end
      r_total  <= r_total + w_rm_count;
      r_sweeps <= r_sweeps + SW_W'(1);
      if ((w_rm_count != '0) && w_sweep_last) begin
        r_limit_hit <= 1'b1;
      end
    end else if (w_accept) begin
      r_grid[r_row_ptr] <= bus.load_row;
      r_limit_hit       <= 1'b0;
      if (w_last_row) begin
        r_row_ptr <= '0;
        r_total   <= '0;
        r_sweeps  <= '0;
      end else begin
        r_row_ptr <= r_row_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iterative_grid_remover.sv
// Testbench for iterative_grid_remover: three instances (3x3, 16x16 default,
// 3x3 with a single-sweep limit) driven by directed steps with a result scoreboard.
module tb_iterative_grid_remover;

  typedef struct {
    int          tot;
    int          sw;
    int          lim;
    int          cyc;
    logic [255:0] g;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [3];
  logic        v_d   [3];
  logic [15:0] row_d [3];
  logic [3:0]  sel_d [3];

  logic [31:0] m_done [3];
  logic [31:0] m_busy [3];
  logic [31:0] m_lim  [3];
  logic [31:0] m_tot  [3];
  logic [31:0] m_sw   [3];
  logic [31:0] m_rdy  [3];
  logic [31:0] m_rd   [3];

  logic       busy_a, done_a, lim_a, busy_b, done_b, lim_b, busy_c, done_c, lim_c;
  logic [3:0] tot_a, tot_c;
  logic [8:0] tot_b;
  logic [7:0] sw_a, sw_b;
  logic [0:0] sw_c;

  exp_t        sbq [$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] pat [16];

  iterative_grid_remover_if #(.WIDTH(3),  .DEPTH(3))  ia ();
  iterative_grid_remover_if #(.WIDTH(16), .DEPTH(16)) ib ();
  iterative_grid_remover_if #(.WIDTH(3),  .DEPTH(3))  ic ();

  assign ia.load_valid = v_d[0];
  assign ia.load_row   = row_d[0][2:0];
  assign ia.rd_sel     = sel_d[0][1:0];
  assign ib.load_valid = v_d[1];
  assign ib.load_row   = row_d[1];
  assign ib.rd_sel     = sel_d[1];
  assign ic.load_valid = v_d[2];
  assign ic.load_row   = row_d[2][2:0];
  assign ic.rd_sel     = sel_d[2][1:0];

  iterative_grid_remover #(.WIDTH(3), .DEPTH(3), .THRESH(4), .MAX_SWEEPS(255)) dut_a (
    .clk(clk), .rst(rst_v[0]), .bus(ia.slave), .busy(busy_a), .done(done_a),
    .limit_hit(lim_a), .total_removed(tot_a), .sweep_count(sw_a));

  iterative_grid_remover dut_b (
    .clk(clk), .rst(rst_v[1]), .bus(ib.slave), .busy(busy_b), .done(done_b),
    .limit_hit(lim_b), .total_removed(tot_b), .sweep_count(sw_b));

  iterative_grid_remover #(.WIDTH(3), .DEPTH(3), .THRESH(4), .MAX_SWEEPS(1)) dut_c (
    .clk(clk), .rst(rst_v[2]), .bus(ic.slave), .busy(busy_c), .done(done_c),
    .limit_hit(lim_c), .total_removed(tot_c), .sweep_count(sw_c));

  assign m_done[0] = 32'(done_a);  assign m_done[1] = 32'(done_b);  assign m_done[2] = 32'(done_c);
  assign m_busy[0] = 32'(busy_a);  assign m_busy[1] = 32'(busy_b);  assign m_busy[2] = 32'(busy_c);
  assign m_lim[0]  = 32'(lim_a);   assign m_lim[1]  = 32'(lim_b);   assign m_lim[2]  = 32'(lim_c);
  assign m_tot[0]  = 32'(tot_a);   assign m_tot[1]  = 32'(tot_b);   assign m_tot[2]  = 32'(tot_c);
  assign m_sw[0]   = 32'(sw_a);    assign m_sw[1]   = 32'(sw_b);    assign m_sw[2]   = 32'(sw_c);
  assign m_rdy[0]  = 32'(ia.load_ready);
  assign m_rdy[1]  = 32'(ib.load_ready);
  assign m_rdy[2]  = 32'(ic.load_ready);
  assign m_rd[0]   = 32'(ia.rd_row);
  assign m_rd[1]   = 32'(ib.rd_row);
  assign m_rd[2]   = 32'(ic.rd_row);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference sweep model, one pass over a private copy of the grid per sweep
  task automatic model(input int depth, input int width, input int thresh, input int maxsw,
                       input logic [15:0] rows [16], output exp_t e);
    logic [15:0] cur [16];
    logic [15:0] nxt [16];
    int rm, n, rr, cc;
    cur = rows;
    e.tot = 0; e.sw = 0; e.lim = 0; e.g = '0;
    while (1) begin
      rm = 0;
      for (int r = 0; r < 16; r++) nxt[r] = cur[r];
      for (int r = 0; r < depth; r++) begin
        for (int c = 0; c < width; c++) begin
          if (cur[r][c]) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
              for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr; cc = c + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < depth && cc >= 0 && cc < width)
                  if (cur[rr][cc]) n++;
              end
            end
            if (n < thresh) begin
              nxt[r][c] = 1'b0;
              rm++;
            end
          end
        end
      end
      e.sw++;
      e.tot += rm;
      cur = nxt;
      if (rm == 0) break;
      if (e.sw >= maxsw) begin
        e.lim = 1;
        break;
      end
    end
    e.cyc = e.sw;
    for (int r = 0; r < 16; r++) e.g[r*16 +: 16] = cur[r];
  endtask

  task automatic chk_reset(input int s, input int depth);
    chk($sformatf("rst_rdy%0d", s),  m_rdy[s],  32'd1);
    chk($sformatf("rst_done%0d", s), m_done[s], 32'd0);
    chk($sformatf("rst_busy%0d", s), m_busy[s], 32'd0);
    chk($sformatf("rst_tot%0d", s),  m_tot[s],  32'd0);
    chk($sformatf("rst_sw%0d", s),   m_sw[s],   32'd0);
    chk($sformatf("rst_lim%0d", s),  m_lim[s],  32'd0);
    for (int r = 0; r < depth; r++) begin
      sel_d[s] = 4'(r);
      #1;
      chk($sformatf("rst_row%0d_%0d", s, r), m_rd[s], 32'd0);
    end
  endtask

  // Loads depth rows; returns 1 time unit after the edge that accepted the last row
  task automatic load_grid(input int s, input int depth, input logic [15:0] rows [16],
                           input bit gaps, input bit hold);
    for (int i = 0; i < depth; i++) begin
      if (gaps && i > 0) @(posedge clk);
      @(negedge clk);
      chk($sformatf("ld_rdy%0d_%0d", s, i), m_rdy[s], 32'd1);
      v_d[s]   = 1'b1;
      row_d[s] = rows[i];
      @(posedge clk);
      #1;
      chk($sformatf("ld_done%0d_%0d", s, i), m_done[s], 32'd0);
      if (hold && i == depth - 1) row_d[s] = 16'h0005;
      else v_d[s] = 1'b0;
    end
  endtask

  // Waits for done, then compares counts, latency and final grid against the scoreboard
  task automatic run_check(input int s, input int depth, input bit hold);
    exp_t e;
    int   cyc;
    bit   got;
    e   = sbq.pop_front();
    cyc = 0;
    got = 1'b0;
    chk($sformatf("busy%0d", s), m_busy[s], 32'd1);
    while (cyc < 600 && !got) begin
      if (hold) chk($sformatf("hold_rdy%0d", s), m_rdy[s], 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      if (m_done[s] == 32'd1) got = 1'b1;
    end
    v_d[s] = 1'b0;
    chk($sformatf("done_seen%0d", s), 32'(got), 32'd1);
    chk($sformatf("latency%0d", s), 32'(cyc), 32'(e.cyc));
    chk($sformatf("total%0d", s), m_tot[s], 32'(e.tot));
    chk($sformatf("sweeps%0d", s), m_sw[s], 32'(e.sw));
    chk($sformatf("limit%0d", s), m_lim[s], 32'(e.lim));
    chk($sformatf("idle%0d", s), m_busy[s], 32'd0);
    chk($sformatf("done_rdy%0d", s), m_rdy[s], 32'd1);
    for (int r = 0; r < depth; r++) begin
      sel_d[s] = 4'(r);
      #1;
      chk($sformatf("row%0d_%0d", s, r), m_rd[s], 32'(e.g[r*16 +: 16]));
    end
    if (depth == 3) begin
      sel_d[s] = 4'd3;
      #1;
      chk($sformatf("row_oor%0d", s), m_rd[s], 32'd0);
    end
  endtask

  task automatic push_exp(input int tot, input int sw, input int lim, input logic [255:0] g);
    exp_t e;
    e.tot = tot; e.sw = sw; e.lim = lim; e.cyc = sw; e.g = g;
    sbq.push_back(e);
  endtask

  task automatic set_pat3(input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
    for (int r = 0; r < 16; r++) pat[r] = '0;
    pat[0] = 16'(r0); pat[1] = 16'(r1); pat[2] = 16'(r2);
  endtask

  initial begin
    exp_t e;
    logic [255:0] g;
    for (int s = 0; s < 3; s++) begin
      rst_v[s] = 1'b1; v_d[s] = 1'b0; row_d[s] = '0; sel_d[s] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0, 3);
    chk_reset(1, 16);
    chk_reset(2, 3);
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst_v[s] = 1'b0;

    // 3x3 all ones: removes 4,4,1,0
    set_pat3(3'b111, 3'b111, 3'b111);
    push_exp(9, 4, 0, '0);
    load_grid(0, 3, pat, 1'b0, 1'b0);
    run_check(0, 3, 1'b0);

    // Same grid with a gap between rows, loaded from DONE
    push_exp(9, 4, 0, '0);
    load_grid(0, 3, pat, 1'b1, 1'b0);
    run_check(0, 3, 1'b0);

    // load_valid held with other data during sweeping
    push_exp(9, 4, 0, '0);
    load_grid(0, 3, pat, 1'b0, 1'b1);
    run_check(0, 3, 1'b1);

    // X shape: corners go first, centre next
    set_pat3(3'b101, 3'b010, 3'b101);
    push_exp(5, 3, 0, '0);
    load_grid(0, 3, pat, 1'b0, 1'b0);
    run_check(0, 3, 1'b0);

    // Reset during the second sweep, then an identical rerun
    set_pat3(3'b111, 3'b111, 3'b111);
    load_grid(0, 3, pat, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_tot", m_tot[0], 32'd4);
    chk("mid_sw", m_sw[0], 32'd1);
    chk("mid_busy", m_busy[0], 32'd1);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    chk_reset(0, 3);
    @(negedge clk);
    rst_v[0] = 1'b0;
    push_exp(9, 4, 0, '0);
    load_grid(0, 3, pat, 1'b0, 1'b0);
    run_check(0, 3, 1'b0);

    // Single-sweep limit: stops while still removing
    g = '0;
    g[0*16 +: 16] = 16'h0002; g[1*16 +: 16] = 16'h0007; g[2*16 +: 16] = 16'h0002;
    push_exp(4, 1, 1, g);
    load_grid(2, 3, pat, 1'b0, 1'b0);
    run_check(2, 3, 1'b0);

    // 16x16 empty grid: one sweep, nothing removed
    for (int r = 0; r < 16; r++) pat[r] = '0;
    model(16, 16, 4, 255, pat, e);
    sbq.push_back(e);
    load_grid(1, 16, pat, 1'b0, 1'b0);
    run_check(1, 16, 1'b0);

    // 16x16 random grids of varying density
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++) begin
        pat[r] = (k == 0) ? 16'($urandom) : (k == 1) ? 16'($urandom | $urandom) : 16'hffff;
      end
      model(16, 16, 4, 255, pat, e);
      sbq.push_back(e);
      load_grid(1, 16, pat, (k == 1), 1'b0);
      run_check(1, 16, 1'b0);
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/iterative_grid_remover.md
ITERATIVE_GRID_REMOVER -- requirements
Module: iterative_grid_remover

Interface
REQ-001 SHALL have parameter WIDTH, default 16, columns per row (>=2).
REQ-002 SHALL have parameter DEPTH, default 16, rows (>=2).
REQ-003 SHALL have parameter THRESH, default 4; a set cell with fewer than THRESH set 8-neighbours is removable.
REQ-004 SHALL have parameter MAX_SWEEPS, default 255, sweep limit (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port load_valid  input  1  load_row holds a valid grid row.
REQ-008 SHALL have port load_ready  output  1  block accepts a row this cycle.
REQ-009 SHALL have port load_row  input  WIDTH  row data, bit j = column j, 1 = paper.
REQ-010 SHALL have port rd_sel  input  clog2(DEPTH)  row select for readout.
REQ-011 SHALL have port rd_row  output  WIDTH  combinational current-grid row rd_sel (0 if rd_sel>=DEPTH).
REQ-012 SHALL have port busy  output  1  sweeping in progress.
REQ-013 SHALL have port done  output  1  result valid, level.
REQ-014 SHALL have port limit_hit  output  1  stopped at MAX_SWEEPS with last sweep still removing.
REQ-015 SHALL have port total_removed  output  clog2(WIDTH*DEPTH+1)  cells removed across all sweeps.
REQ-016 SHALL have port sweep_count  output  clog2(MAX_SWEEPS+1)  sweeps executed, including the final zero-removal sweep.

Function
REQ-017 SHALL implement states LOAD, SWEEP, DONE.
REQ-018 LOAD: load_ready=1; each load_valid&&load_ready writes load_row to row index row_ptr, row_ptr increments 0..DEPTH-1.
REQ-019 Acceptance of row DEPTH-1 SHALL reset row_ptr to 0, clear total_removed/sweep_count/limit_hit, and enter SWEEP next cycle.
REQ-020 SWEEP: load_ready=0, busy=1, load_valid ignored; exactly one full sweep per clock.
REQ-021 Sweep SHALL evaluate every cell against the grid snapshot at the start of that cycle (simultaneous update, no intra-sweep propagation); out-of-grid neighbours count as 0.
REQ-022 Each sweep SHALL clear all removable cells, add their count to total_removed, increment sweep_count.
REQ-023 Sweep removing 0 cells SHALL move to DONE next cycle (done=1, limit_hit=0).
REQ-024 Sweep removing >0 cells when sweep_count reaches MAX_SWEEPS SHALL move to DONE with limit_hit=1.
REQ-025 DONE: done=1, busy=0, load_ready=1, outputs and grid held; accepting a row SHALL clear done/limit_hit and behave as REQ-018 at row 0.
REQ-026 total_removed SHALL never wrap (bounded by WIDTH*DEPTH); sweep_count never exceeds MAX_SWEEPS.
REQ-027 Neighbour count SHALL be 4 bits minimum; comparison unsigned.
REQ-028 Latency: last row accepted at cycle N -> first sweep at N+1; k sweeps -> done at N+k+1.
REQ-029 Empty grid SHALL yield one sweep, total_removed=0, sweep_count=1.

Reset
REQ-030 rst=1 at a rising edge SHALL, in any state including mid-load or mid-sweep, set state LOAD, row_ptr=0, grid all 0, total_removed=0, sweep_count=0, done=0, busy=0, limit_hit=0.
REQ-031 During rst load_ready SHALL read 1 (LOAD), and no row is written in the reset cycle.
REQ-032 rst SHALL take priority over load_valid and sweep updates in the same cycle.

Verification
REQ-033 WIDTH=DEPTH=3, THRESH=4, all rows 3'b111 -> sweeps remove 4,4,1,0; total_removed=9, sweep_count=4, done at N+5, all rd_row=0.
REQ-034 All-zero grid (16x16 default) -> total_removed=0, sweep_count=1, done one cycle after sweep, limit_hit=0.
REQ-035 MAX_SWEEPS=1, 3x3 all ones -> DONE after one sweep, total_removed=4, limit_hit=1, rd_row(1)=3'b111.
REQ-036 load_valid held high during SWEEP with different data -> grid and counts unaffected, load_ready=0 throughout.
REQ-037 rst asserted in the second sweep of REQ-033 -> next cycle LOAD, all outputs 0, reload and rerun gives identical REQ-033 result.
REQ-038 load_valid gaps (valid every other cycle) while loading -> rows land in order, result equals gap-free load.
